// File: rtl/wb_board_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter for the shared game-board RAM.
// Optional stalled-strobe timeout is built when WB_ARB_TIMEOUT_EN is defined.
module wb_board_arbiter #(
    parameter int ADR_W          = 12,
    parameter int DAT_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_w_i,
    output logic [DAT_W-1:0] m0_dat_r_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_w_i,
    output logic [DAT_W-1:0] m1_dat_r_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_w_o,
    input  logic [DAT_W-1:0] s_dat_r_i,
    input  logic             s_ack_i,
    output logic [1:0]       grant_o
);

    // Encoding doubles as the one-hot grant vector {M1,M0}.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;   // 1 = M1 was granted most recently

    logic             sel0, sel1;
    logic             act_cyc, act_stb, act_we;
    logic [ADR_W-1:0] act_adr;
    logic [DAT_W-1:0] act_dat;
    logic             stb_block;
    logic             to_err;
    logic             ack_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_q) begin
                        state_d = GNT0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = GNT1;
                        last_d  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc_i) state_d = IDLE;
            GNT1:    if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sel0    = (state_q == GNT0);
    assign sel1    = (state_q == GNT1);
    assign grant_o = state_q;

    always_comb begin
        act_cyc = 1'b0;
        act_stb = 1'b0;
        act_we  = 1'b0;
        act_adr = '0;
        act_dat = '0;
        if (sel0) begin
            act_cyc = m0_cyc_i;
            act_stb = m0_stb_i;
            act_we  = m0_we_i;
            act_adr = m0_adr_i;
            act_dat = m0_dat_w_i;
        end else if (sel1) begin
            act_cyc = m1_cyc_i;
            act_stb = m1_stb_i;
            act_we  = m1_we_i;
            act_adr = m1_adr_i;
            act_dat = m1_dat_w_i;
        end
    end

    assign s_cyc_o   = act_cyc;
    assign s_stb_o   = act_cyc & act_stb & ~stb_block;
    assign s_we_o    = act_we;
    assign s_adr_o   = act_adr;
    assign s_dat_w_o = act_dat;

    // An ack arriving after the granted master dropped cyc belongs to an aborted cycle.
    assign ack_ok     = s_ack_i & act_cyc;
    assign m0_ack_o   = sel0 & ack_ok;
    assign m1_ack_o   = sel1 & ack_ok;
    assign m0_dat_r_o = sel0 ? s_dat_r_i : '0;
    assign m1_dat_r_o = sel1 ? s_dat_r_i : '0;
    assign m0_err_o   = sel0 & to_err;
    assign m1_err_o   = sel1 & to_err;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             block_q, block_d;
    logic             stall;

    assign stall     = s_stb_o & ~s_ack_i;
    // The cycle that would bring the count to TIMEOUT_CYCLES is the error cycle.
    assign to_err    = stall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign stb_block = block_q;

    always_comb begin
        cnt_d   = cnt_q;
        block_d = block_q;
        if ((state_d != state_q) || s_ack_i || to_err) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_d != state_q) begin
            block_d = 1'b0;
        end else if (to_err) begin
            block_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            block_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign to_err         = 1'b0;
    assign stb_block      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_board_arbiter.sv
// Scoreboarded bench for wb_board_arbiter: directed arbitration/abort/timeout cases plus
// randomized traffic from both masters against a bench-side board RAM and shadow model.
module tb_wb_board_arbiter;

    typedef struct packed {
        logic       we;
        logic [7:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mcyc = '0, mstb = '0, mwe = '0;
    logic [11:0] madr [2];
    logic [7:0]  mdw  [2];
    logic [7:0]  mdr0, mdr1;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [11:0] s_adr;
    logic [7:0]  s_dat_w, s_dat_r;
    logic [1:0]  grant;
    logic [1:0]  mack;

    int   vectors = 0;
    int   miscompares = 0;
    int   ack_cnt [2];
    exp_t q0[$], q1[$];
    exp_t mon_e;
    bit   mon_have;
    logic [7:0] shadow [0:4095];

    // Slave: board RAM, acks one cycle after strobe, or manual ack for directed cases.
    logic [7:0] ram [0:4095];
    bit         filled = 1'b0;
    bit         slave_auto = 1'b1;
    bit         ack_man = 1'b0;
    logic       ack_auto_q = 1'b0;
    logic [7:0] rdat_q = '0;

    assign s_ack   = slave_auto ? ack_auto_q : ack_man;
    assign s_dat_r = rdat_q;
    assign mack    = {m1_ack, m0_ack};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 7 + 3);
            filled <= 1'b1;
        end else if (s_cyc && s_stb && !ack_auto_q) begin
            if (s_we) ram[s_adr] <= s_dat_w;
            else      rdat_q     <= ram[s_adr];
        end
        ack_auto_q <= s_cyc && s_stb && !ack_auto_q;
    end

    wb_board_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_adr_i(madr[0]),
        .m0_dat_w_i(mdw[0]), .m0_dat_r_o(mdr0), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_adr_i(madr[1]),
        .m1_dat_w_i(mdw[1]), .m1_dat_r_o(mdr1), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_w_o(s_dat_w), .s_dat_r_i(s_dat_r), .s_ack_i(s_ack), .grant_o(grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] mdr(input int m);
        return (m == 0) ? mdr0 : mdr1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int m, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            if (mack[m]) ok = 1'b1;
        end
        tick();
    endtask

    task automatic issue(input int m);
        logic [11:0] a;
        logic [7:0]  d;
        logic        we;
        a  = {m[0], 11'($urandom)};
        d  = 8'($urandom);
        we = 1'($urandom_range(1));
        if (we) shadow[a] = d;
        if (m == 0) q0.push_back('{we, shadow[a]});
        else        q1.push_back('{we, shadow[a]});
        mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = we; madr[m] = a; mdw[m] = d;
        $display("txn m%0d %s adr=0x%03h dat=0x%02h", m, we ? "WR" : "RD", a, shadow[a]);
    endtask

    // Monitor: every routed ack must match the oldest outstanding expectation for that master.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                if (mack[m]) begin
                    mon_have = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    check($sformatf("m%0d_ack_expected", m), 32'(mon_have), 32'd1);
                    check($sformatf("m%0d_ack_granted", m), 32'(grant[m]), 32'd1);
                    if (mon_have) begin
                        mon_e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        ack_cnt[m]++;
                        if (!mon_e.we) check($sformatf("m%0d_rdata", m), 32'(mdr(m)), 32'(mon_e.d));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        bit         ok;
        int         acks_before;
        logic [1:0] ackd;
        bit   [1:0] busy;
        madr[0] = '0; madr[1] = '0; mdw[0] = '0; mdw[1] = '0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        for (int i = 0; i < 4096; i++) shadow[i] = 8'(i * 7 + 3);

        // Reset holds everything quiet even with a request pending.
        mcyc[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_m0_ack", 32'(m0_ack), 32'd0);
        check("rst_m0_dat_r", 32'(mdr0), 32'd0);
        check("rst_s_adr", 32'(s_adr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_release_grant", 32'(grant), 32'd1);
        check("rst_release_s_cyc", 32'(s_cyc), 32'd1);
        mcyc[0] = 1'b0;
        tick(); tick();
        check("idle_grant", 32'(grant), 32'd0);

        // Tie right after reset goes to M0, then M1 after one idle cycle.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        mcyc = 2'b11;
        tick();
        check("tie_first", 32'(grant), 32'd1);
        mcyc[0] = 1'b0;
        tick();
        check("tie_gap_idle", 32'(grant), 32'd0);
        tick();
        check("tie_second", 32'(grant), 32'd2);
        mcyc[1] = 1'b0;
        tick(); tick();

        // Block read by M1, four beats in one cyc.
        acks_before = ack_cnt[1];
        mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            madr[1] = 12'h010 + 12'(i);
            q1.push_back('{1'b0, shadow[madr[1]]});
            $display("txn m1 RD adr=0x%03h dat=0x%02h", madr[1], shadow[madr[1]]);
            wait_ack(1, ok);
            check("blk_ack_seen", 32'(ok), 32'd1);
            check("blk_grant_held", 32'(grant), 32'd2);
        end
        mcyc[1] = 1'b0; mstb[1] = 1'b0;
        tick();
        check("blk_ack_count", 32'(ack_cnt[1] - acks_before), 32'd4);
        check("blk_queue_empty", 32'(q1.size()), 32'd0);
        tick();

        // Isolation: M0 write waits behind M1's held cyc.
        mcyc[1] = 1'b1;
        tick(); tick();
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b1; madr[0] = 12'h123; mdw[0] = 8'hA5;
        shadow[12'h123] = 8'hA5;
        q0.push_back('{1'b1, 8'hA5});
        $display("txn m0 WR adr=0x123 dat=0xa5");
        for (int i = 0; i < 4; i++) begin
            check("iso_no_s_we", 32'(s_we), 32'd0);
            check("iso_grant_m1", 32'(grant), 32'd2);
            tick();
        end
        mcyc[1] = 1'b0;
        wait_ack(0, ok);
        check("iso_ack_seen", 32'(ok), 32'd1);
        check("iso_grant_m0", 32'(grant), 32'd1);
        mcyc[0] = 1'b0; mstb[0] = 1'b0; mwe[0] = 1'b0;
        tick();
        check("iso_ram_123", 32'(ram[12'h123]), 32'hA5);

        // Abort: M0 drops cyc before the (late) slave ack.
        slave_auto = 1'b0; ack_man = 1'b0;
        mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 12'h050;
        tick(); tick();
        mcyc[0] = 1'b0; mstb[0] = 1'b0;
        #1;
        check("abort_s_cyc_falls", 32'(s_cyc), 32'd0);
        tick();
        ack_man = 1'b1;
        #1;
        check("abort_no_ack", 32'(m0_ack), 32'd0);
        check("abort_grant_idle", 32'(grant), 32'd0);
        tick();
        ack_man = 1'b0;

        // Hung slave: timeout error on the 16th stalled cycle when built in.
        mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 12'h060;
        tick();
        for (int k = 1; k <= 20; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
            check($sformatf("to_err_c%0d", k), 32'(m0_err), 32'(k == 16));
            check($sformatf("to_stb_c%0d", k), 32'(s_stb), 32'(k <= 16));
`else
            check($sformatf("to_err_c%0d", k), 32'(m0_err), 32'd0);
            check($sformatf("to_stb_c%0d", k), 32'(s_stb), 32'd1);
`endif
            check($sformatf("to_grant_c%0d", k), 32'(grant), 32'd1);
            tick();
        end
        mcyc[0] = 1'b0; mstb[0] = 1'b0;
        tick(); tick();
        check("to_release", 32'(grant), 32'd0);
        slave_auto = 1'b1;
        tick();

        // Randomized traffic: each master owns half the address space of the shadow model.
        busy = '0;
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            ackd = mack;
            tick();
            for (int m = 0; m < 2; m++) begin
                if (busy[m] && ackd[m]) begin
                    if (c < 700 && $urandom_range(2) == 0) issue(m);
                    else begin
                        mcyc[m] = 1'b0; mstb[m] = 1'b0; busy[m] = 1'b0;
                    end
                end else if (!busy[m] && c < 700 && $urandom_range(3) == 0) begin
                    issue(m);
                    busy[m] = 1'b1;
                end
            end
        end
        check("rand_all_done", 32'(busy), 32'd0);
        check("rand_q0_drained", 32'(q0.size()), 32'd0);
        check("rand_q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
